seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DWELL, default 50000: clock cycles per digit slot; SHALL satisfy DWELL >= DEAD + 2.
REQ-002 Parameter DEAD, default 500: dark cycles at the start of each slot; SHALL satisfy DEAD >= 1.
REQ-003 Parameter BLINK_FRAMES, default 128: frames per blink half-period; SHALL satisfy BLINK_FRAMES >= 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 display  input  42  six 7-segment patterns, active-high (1 = lit); digit k = display[7k+6:7k], bit 0 = segment a ... bit 6 = segment g.
REQ-007 blank  input  1  1 = all anodes off.
REQ-008 blink_en  input  6  per-digit blink enable; bit k controls digit k.
REQ-009 seg_n  output  7  active-low segment drive for the currently selected digit.
REQ-010 an_n  output  6  active-low anode drive; at most one bit low at any time.
REQ-011 frame_tick  output  1  single-cycle pulse at each frame start.

Function
REQ-012 Slot counter pre SHALL count 0..DWELL-1 and wrap to 0; digit index idx SHALL advance by 1 when pre == DWELL-1, wrapping from 5 to 0.
REQ-013 Shadow register SHALL load display only on cycles where idx == 0 and pre == 0, so the pattern is frozen for the whole frame (no tearing); display changes mid-frame SHALL NOT appear until the next frame.
REQ-014 frame_tick SHALL be registered and high for exactly the one cycle after each cycle with idx == 0 and pre == 0, including the first such cycle after reset deasserts.
REQ-015 Frame counter fc SHALL count frame starts 0..BLINK_FRAMES-1; on wrap, blink_off SHALL toggle.
REQ-016 Digit i lit condition: idx == i, pre >= DEAD, blank == 0, and NOT (blink_en[i] == 1 AND blink_off == 1).
REQ-017 an_n and seg_n SHALL be registered, 1-cycle latency from the (idx, pre) state: an_n[i] = 0 iff digit i is lit; seg_n = ~shadow[7*idx+6 : 7*idx] when lit, else 7'h7F.
REQ-018 Dark interval: for pre < DEAD, an_n = 6'h3F and seg_n = 7'h7F (anti-ghosting).
REQ-019 blank and blink_en SHALL be sampled every cycle (not frozen per frame) and take effect on the next output update.
REQ-020 Full scan period SHALL be exactly 6*DWELL cycles; frame_tick period SHALL equal 6*DWELL cycles.
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 While reset = 1 at a clock edge: pre = 0, idx = 0, fc = 0, blink_off = 0, shadow = 0, an_n = 6'h3F, seg_n = 7'h7F, frame_tick = 0.
REQ-023 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately; scanning SHALL restart from idx 0, pre 0 on the first cycle after deassertion, with shadow reloaded that cycle.

Verification (DWELL=8, DEAD=2, BLINK_FRAMES=2)
REQ-024 Reset release, display = 42'h0 except digit 0 = 7'h3F -> frame_tick high 1 cycle after release; an_n = 6'h3F for 2 cycles, then an_n = 6'h3E, seg_n = 7'h40 for 6 cycles; then digit 1 slot with seg_n = 7'h7F.
REQ-025 Free-running scan -> an_n low bit walks 0..5 and wraps to 0; frame_tick every 48 cycles; never two an_n bits low at once.
REQ-026 Change display digit 0 from 7'h06 to 7'h5B while idx = 3 -> seg_n for digit 0 stays 7'h79 for the rest of the frame; shows 7'h24 in the next frame.
REQ-027 blink_en = 6'b000010 -> digit 1 lit in frames 0-1, dark (an_n[1] = 1) in frames 2-3, lit in frames 4-5; other digits unaffected.
REQ-028 blank = 1 for 20 cycles mid-frame -> an_n = 6'h3F, seg_n = 7'h7F from 1 cycle after assertion until 1 cycle after deassertion; scan timing and frame_tick period unchanged.
REQ-029 Assert reset for 1 cycle at idx = 4, pre = 5 -> outputs dark the next cycle; frame_tick pulses on the first cycle after reset deasserts; scan resumes at digit 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed six-digit 7-segment driver with per-frame shadowing,
// dead-time anti-ghosting and per-digit blinking; all outputs registered.
module seg_scan_driver #(
    parameter int DWELL        = 50000,
    parameter int DEAD         = 500,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [41:0] display,
    input  logic        blank,
    input  logic [5:0]  blink_en,
    output logic [6:0]  seg_n,
    output logic [5:0]  an_n,
    output logic        frame_tick
);
    localparam int PW = $clog2(DWELL);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(DWELL - 1);
    localparam logic [PW-1:0] PRE_DEAD = PW'(DEAD);
    localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [FW-1:0] r_fc;
    logic          r_blink_off;
    logic [41:0]   r_shadow;
    logic          w_slot_end, w_frame_start, w_frame_end, w_lit;
    logic [6:0]    w_digit;

    always_comb begin
        w_slot_end    = r_pre == PRE_MAX;
        w_frame_start = r_idx == 3'd0 && r_pre == '0;
        w_frame_end   = w_slot_end && r_idx == 3'd5;
        w_lit         = r_pre >= PRE_DEAD && !blank && !(blink_en[r_idx] && r_blink_off);
        w_digit       = r_shadow[7*r_idx +: 7];
    end

    // Blink phase advances on completed frames, so frames 0..BLINK_FRAMES-1 after reset stay lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre       <= '0;
            r_idx       <= 3'd0;
            r_fc        <= '0;
            r_blink_off <= 1'b0;
            r_shadow    <= '0;
            an_n        <= 6'h3F;
            seg_n       <= 7'h7F;
            frame_tick  <= 1'b0;
        end else begin
            r_pre      <= w_slot_end ? '0 : r_pre + 1'b1;
            r_idx      <= w_slot_end ? (r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1) : r_idx;
            r_shadow   <= w_frame_start ? display : r_shadow;
            frame_tick <= w_frame_start;
            an_n       <= w_lit ? ~(6'd1 << r_idx) : 6'h3F;
            seg_n      <= w_lit ? ~w_digit : 7'h7F;
            if (w_frame_end) begin
                r_fc        <= r_fc == FC_MAX ? '0 : r_fc + 1'b1;
                r_blink_off <= r_fc == FC_MAX ? ~r_blink_off : r_blink_off;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random stimulus checked every cycle against a
// time-based reference model of the scan (slot, digit and frame derived from cycles since reset).
module tb_seg_scan_driver;
    localparam int DW = 8;
    localparam int DD = 2;
    localparam int BF = 2;
    localparam int FR = 6 * DW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [41:0] display = '0;
    logic        blank = 1'b0;
    logic [5:0]  blink_en = '0;
    logic [6:0]  seg_n;
    logic [5:0]  an_n;
    logic        frame_tick;

    int          t = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [41:0] sh_m = '0;

    seg_scan_driver #(.DWELL(DW), .DEAD(DD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .display(display), .blank(blank), .blink_en(blink_en),
        .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, t, got, exp);
        end
    endtask

    // Model: state at cycle t (since reset release) is digit (t/DW)%6, slot position t%DW,
    // frame t/FR; blink is off in frames where (frame/BF) is odd.
    task automatic step();
        int idx, pre, fr;
        logic lit, e_ft;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        idx  = (t / DW) % 6;
        pre  = t % DW;
        fr   = t / FR;
        lit  = !reset && pre >= DD && !blank && !(blink_en[idx] && ((fr / BF) % 2 == 1));
        e_an = lit ? ~(6'd1 << idx) : 6'h3F;
        e_seg = lit ? ~sh_m[7*idx +: 7] : 7'h7F;
        e_ft = !reset && (t % FR == 0);
        if (reset) sh_m = '0;
        else if (t % FR == 0) sh_m = display;
        @(posedge clk);
        #1;
        chk("an_n", {1'b0, an_n}, {1'b0, e_an});
        chk("seg_n", seg_n, e_seg);
        chk("frame_tick", {6'b0, frame_tick}, {6'b0, e_ft});
        chk("one_anode", 7'($countones(~an_n) <= 1), 7'd1);
        t = reset ? 0 : t + 1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        display = 42'h3F;
        run(3);
        chk("reset_an", {1'b0, an_n}, 7'h3F);
        chk("reset_ft", {6'b0, frame_tick}, 7'd0);
        reset = 1'b0;
        step();
        chk("first_tick", {6'b0, frame_tick}, 7'd1);
        run(2);
        chk("digit0_an", {1'b0, an_n}, 7'h3E);
        chk("digit0_seg", seg_n, 7'h40);
        run(2 * FR);
        // Display change mid-frame must wait for the next frame
        while (t % FR != 0) step();
        display[6:0] = 7'h06;
        step();
        while ((t / DW) % 6 != 3) step();
        display[6:0] = 7'h5B;
        while (t % FR != 0) step();
        while (t % FR != DD + 1) step();
        chk("shadow_next_frame", seg_n, 7'h24);
        // Blink on digit 1 across several blink phases
        blink_en = 6'b000010;
        run(6 * FR);
        blink_en = '0;
        // Blank burst mid-frame
        run(13);
        blank = 1'b1;
        run(20);
        blank = 1'b0;
        run(FR);
        // One-cycle reset at digit 4, slot position 5
        while (!((t / DW) % 6 == 4 && t % DW == 5)) step();
        reset = 1'b1;
        step();
        chk("midreset_dark", {1'b0, an_n}, 7'h3F);
        reset = 1'b0;
        step();
        chk("midreset_tick", {6'b0, frame_tick}, 7'd1);
        run(FR);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) display = {10'($urandom), $urandom};
            if ($urandom_range(0, 49) == 0) blink_en = 6'($urandom);
            blank = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 399) == 0;
            step();
        end
        reset = 1'b0;
        blank = 1'b0;
        run(FR);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
